// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - iterative AES-128 key schedule, one round key per stream transfer
// Round keys 0..10 are presented on a valid/ready stream; the next key is built combinationally from the held one.

module aes_rot_word (
  input  logic [31:0] word,
  output logic [31:0] rotated
);
  assign rotated = {word[23:0], word[31:24]};
endmodule

module aes_sub_word (
  input  logic [31:0] word,
  output logic [31:0] subbed
);
  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  assign subbed = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
endmodule

module key_expansion_seq #(
  parameter int BYTE       = 8,
  parameter int WORD       = 32,
  parameter int KEY_BITS   = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                ready,
  output logic [KEY_BITS-1:0] round_key,
  output logic                round_key_valid,
  input  logic                round_key_ready,
  output logic [3:0]          round_index,
  output logic                done
);
  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state, state_nxt;
  logic [KEY_BITS-1:0] key_nxt;
  logic [3:0]          index_nxt;
  logic [BYTE-1:0]     rcon, rcon_nxt;
  logic                done_nxt;

  logic [WORD-1:0] w0, w1, w2, w3, rot_w3, sub_w3, temp, n0, n1, n2, n3;
  logic [BYTE-1:0] rcon_xtime;

  assign {w0, w1, w2, w3} = round_key;

  aes_rot_word u_rot (.word(w3), .rotated(rot_w3));
  aes_sub_word u_sub (.word(rot_w3), .subbed(sub_w3));

  assign temp = sub_w3 ^ {rcon, {(WORD-BYTE){1'b0}}};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  // GF(2^8) doubling; 0x80 reduces to 0x1B.
  assign rcon_xtime = {rcon[BYTE-2:0], 1'b0} ^ (rcon[BYTE-1] ? 8'h1b : 8'h00);

  assign ready           = (state == IDLE);
  assign round_key_valid = (state == PRESENT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      round_key   <= '0;
      round_index <= '0;
      rcon        <= 8'h01;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      round_key   <= key_nxt;
      round_index <= index_nxt;
      rcon        <= rcon_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = round_key;
    index_nxt = round_index;
    rcon_nxt  = rcon;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = key_in;
          index_nxt = '0;
          rcon_nxt  = 8'h01;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (round_key_ready) begin
          if (round_index == 4'(NUM_ROUNDS)) begin
            // Last key stays on round_key after completion.
            state_nxt = IDLE;
            index_nxt = '0;
            done_nxt  = 1'b1;
          end else begin
            key_nxt   = {n0, n1, n2, n3};
            index_nxt = round_index + 4'd1;
            rcon_nxt  = rcon_xtime;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb/tb_key_expansion_seq.sv - randomized bench for key_expansion_seq against a FIPS-197 word-level model

module tb_key_expansion_seq;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         round_key_ready = 1'b0;
  logic         ready, round_key_valid, done;
  logic [127:0] round_key;
  logic [3:0]   round_index;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  key_expansion_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in), .ready(ready),
    .round_key(round_key), .round_key_valid(round_key_valid),
    .round_key_ready(round_key_ready), .round_index(round_index), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // S-box derived from the field inverse plus the affine map, not from a table.
  logic [7:0] sbox_m [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] model_round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_tab[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Transaction-level expectation: which expansion is running and which key is due.
  bit           chk_en = 1'b0;
  bit           m_busy, m_done;
  int           m_idx;
  logic [127:0] m_key, m_base;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 0; m_idx = 0; m_key = '0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_base = key_in; m_busy = 1; m_idx = 0; m_key = key_in;
        end
      end else if (round_key_ready) begin
        if (m_idx == 10) begin
          m_busy = 0; m_idx = 0; m_done = 1;
        end else begin
          m_idx++;
          m_key = model_round_key(m_base, m_idx);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {127'b0, ready}, {127'b0, !m_busy});
      check("round_key_valid", {127'b0, round_key_valid}, {127'b0, m_busy});
      check("round_key", round_key, m_key);
      check("round_index", {124'b0, round_index}, 128'(m_idx));
      check("done", {127'b0, done}, {127'b0, m_done});
    end
  end

  logic [127:0] dut_log [11];
  int           valid_cnt;

  // mode 0: always ready; 1: random ready with a 5-cycle stall at round 3; 2: start re-pulsed mid-run
  task automatic run_exp(input logic [127:0] key, input int mode);
    int  cyc = 0;
    int  stall = 0;
    bit  stalled3 = 0, injected = 0;
    valid_cnt = 0;
    start = 1'b1; key_in = key; round_key_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 300) begin
      start = 1'b0;
      if (mode == 1) begin
        if (round_index == 4'd3 && !stalled3) begin stall = 5; stalled3 = 1; end
        if (stall > 0) begin round_key_ready = 1'b0; stall--; end
        else round_key_ready = 1'($urandom % 2);
      end else begin
        round_key_ready = 1'b1;
      end
      if (mode == 2 && round_index == 4'd6 && !injected) begin
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom}; injected = 1;
      end
      if (round_key_valid) begin
        valid_cnt++;
        if (round_key_ready) dut_log[round_index] = round_key;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("run_timeout", {127'b0, cyc >= 300}, 128'b0);
  endtask

  initial begin
    int cyc;
    wait (sbox_m[255] !== 8'hxx);
    // Pin the model to published FIPS-197 vectors.
    check("model_fips_r1", model_round_key(FIPS_KEY, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_fips_r10", model_round_key(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_zero_r1", model_round_key('0, 1), 128'h62636363626363636263636362636363);
    check("model_zero_r10", model_round_key('0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_ready", {127'b0, ready}, 128'd1);
    check("reset_round_key", round_key, 128'h0);
    reset_n = 1'b1;
    round_key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    run_exp(FIPS_KEY, 0);
    check("fips_r0", dut_log[0], FIPS_KEY);
    check("fips_r1", dut_log[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", dut_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_valid_cycles", 128'(valid_cnt), 128'd11);

    run_exp('0, 0);
    check("zero_r1", dut_log[1], 128'h62636363626363636263636362636363);
    check("zero_r10", dut_log[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int t = 0; t < 3; t++) begin
      run_exp(FIPS_KEY, 1);
      for (int r = 0; r <= 10; r++) check("stall_seq", dut_log[r], model_round_key(FIPS_KEY, r));
    end

    for (int t = 0; t < 3; t++) begin
      logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
      run_exp(k, 1);
      check("rand_r10", dut_log[10], model_round_key(k, 10));
    end

    run_exp(FIPS_KEY, 2);
    check("start_ignored_r10", dut_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset while round 5 is presented.
    start = 1'b1; key_in = FIPS_KEY; round_key_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(round_key_valid && round_index == 4'd5) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("reach_r5", {124'b0, round_index}, 128'd5);
    reset_n = 1'b0; round_key_ready = 1'b0;
    @(posedge clk); #1;
    check("midreset_ready", {127'b0, ready}, 128'd1);
    check("midreset_valid", {127'b0, round_key_valid}, 128'd0);
    check("midreset_key", round_key, 128'h0);
    check("midreset_index", {124'b0, round_index}, 128'd0);
    reset_n = 1'b1;
    run_exp(FIPS_KEY, 0);
    check("after_reset_r1", dut_log[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // start held high across done: the second key is taken in the done cycle.
    begin
      logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1; key_in = FIPS_KEY; round_key_ready = 1'b1;
      @(posedge clk); #1;
      key_in = k2;
      cyc = 0;
      while (!done && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      check("held_done_seen", {127'b0, done}, 128'd1);
      check("held_gap_valid", {127'b0, round_key_valid}, 128'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("held_restart_valid", {127'b0, round_key_valid}, 128'd1);
      check("held_restart_key", round_key, k2);
      check("held_restart_index", {124'b0, round_index}, 128'd0);
      cyc = 0;
      while (!done && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      check("held_second_done", {127'b0, done}, 128'd1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Iterative AES-128 key schedule engine that produces all 11 round keys (rounds 0..10) from a 128-bit cipher key.
- Computes one full round key (four words) per accepted transfer.
- Per round it uses the existing RotWord block, a 4-byte SubWord S-box and an internal Rcon generator.
- Sits between the key-load interface and the cipher round datapath.
- Delivers round keys over a valid/ready stream so the consumer can stall it.

Parameters:
BYTE, 8, byte width in bits
WORD, 32, word width in bits
KEY_BITS, 128, cipher/round key width (fixed at 128; other values unsupported)
NUM_ROUNDS, 10, last round index

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  request expansion; sampled only in IDLE
key_in  input  128  cipher key, sampled on the start-accept cycle; w0 = key_in[127:96]
ready  output  1  high in IDLE (engine will accept start)
round_key  output  128  current round key {w4r, w4r+1, w4r+2, w4r+3}
round_key_valid  output  1  round_key/round_index valid
round_key_ready  input  1  consumer accepts the current round key
round_index  output  4  index 0..10 of the presented key
done  output  1  one-cycle pulse after round 10 is accepted

Behaviour:
- One clock, clk. Reset is synchronous and active-low: reset_n is sampled on the rising edge of clk.
- Reset (reset_n=0 at a clk edge), from any state including mid-expansion:
  - state=IDLE, ready=1, round_key=0, round_key_valid=0, round_index=0, done=0, rcon=8'h01.
  - Any in-progress expansion is abandoned.
- States: IDLE, PRESENT.
- IDLE:
  - ready=1, round_key_valid=0.
  - If start=1, then on the next edge: round_key<=key_in, round_index<=0, rcon<=8'h01, state<=PRESENT.
  - Latency from start to first valid is one cycle.
- PRESENT:
  - ready=0, round_key_valid=1.
  - round_key and round_index are held stable while round_key_ready=0, for any stall length.
  - start is ignored.
- Transfer occurs on an edge where round_key_valid=1 and round_key_ready=1.
  - If round_index<10:
    - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
    - n0 = w0^temp, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
    - round_key<={n0,n1,n2,n3}, round_index<=round_index+1.
    - rcon<=xtime(rcon): rcon<<1, XOR 8'h1B if bit7 was set.
    - Stay in PRESENT.
    - The next key is valid in the cycle right after the transfer, so back-to-back throughput is one key per cycle.
  - If round_index==10: state<=IDLE, round_key_valid<=0, done<=1 for exactly one cycle.
    - round_key holds its last value; round_index returns to 0.
- Rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. The 1B step is the wrap/reduction case.
- round_index never exceeds 10 and never wraps.
- start asserted in the same cycle as done:
  - ready is already 1 in that cycle, so start is accepted.
  - round 0 of the new key is valid on the next cycle.
- round_key_ready=1 in IDLE has no effect.
- SubWord is purely combinational (four S-box lookups). The whole round datapath is combinational from the registered round_key and rcon.

Test Plan:
- Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c, round_key_ready held 1:
  - round 0 valid one cycle after start, key = key_in.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses one cycle after round 10 is accepted; 11 consecutive valid cycles in total.
- key_in=0:
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Confirms the 80->1B->36 rcon wrap.
- Backpressure: FIPS key with round_key_ready toggling randomly, and held low 5 cycles at round 3:
  - round_key and round_index are stable while stalled.
  - The sequence is identical to the unstalled run.
- Drive reset_n=0 while round_index=5 is presented:
  - The next cycle shows ready=1, round_key_valid=0, round_key=0, round_index=0.
  - A subsequent start with the FIPS key produces the correct round 1.
- start pulsed during PRESENT with a different key_in:
  - It is ignored; the FIPS sequence continues unchanged.
- start held high across done:
  - The new expansion begins with no idle valid gap beyond one cycle.
  - Round 0 equals the newly sampled key_in.
